// File: rtl/button_event_decoder.sv
// Turns the debounced button level into single-cycle press/release/long/repeat/click pulses.
// The release and repeat pulses are named release_ev and repeat_ev because the bare words are reserved.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int DCLICK_CYCLES = 300,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic button_state,
    output logic press,
    output logic release_ev,
    output logic long_press,
    output logic repeat_ev,
    output logic single_click,
    output logic double_click,
    output logic held
);

    typedef enum logic [2:0] {
        ST_LOCK     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_LONG     = 3'd3,
        ST_WAIT2    = 3'd4,
        ST_PRESSED2 = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic             release_r;
    logic             long_press_r;
    logic             repeat_r;
    logic             single_click_r;
    logic             double_click_r;
    logic             held_r;

    // Decoder FSM: a level change always wins over a terminal count on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_LOCK;
            cnt_r          <= CNT_ZERO;
            press_r        <= 1'b0;
            release_r      <= 1'b0;
            long_press_r   <= 1'b0;
            repeat_r       <= 1'b0;
            single_click_r <= 1'b0;
            double_click_r <= 1'b0;
            held_r         <= 1'b0;
        end else begin
            press_r        <= 1'b0;
            release_r      <= 1'b0;
            long_press_r   <= 1'b0;
            repeat_r       <= 1'b0;
            single_click_r <= 1'b0;
            double_click_r <= 1'b0;
            case (state_r)
                ST_LOCK: begin
                    if (!button_state) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_IDLE: begin
                    if (button_state) begin
                        press_r <= 1'b1;
                        held_r  <= 1'b1;
                        state_r <= ST_PRESSED;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_PRESSED: begin
                    if (!button_state) begin
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                        state_r   <= ST_WAIT2;
                        cnt_r     <= CNT_ZERO;
                    end else if (cnt_r == LONG_LAST) begin
                        long_press_r <= 1'b1;
                        state_r      <= ST_LONG;
                        cnt_r        <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_LONG: begin
                    if (!button_state) begin
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                        cnt_r     <= CNT_ZERO;
                    end else if (cnt_r == REPEAT_LAST) begin
                        repeat_r <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT2: begin
                    if (button_state) begin
                        press_r <= 1'b1;
                        held_r  <= 1'b1;
                        state_r <= ST_PRESSED2;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == DCLICK_LAST) begin
                        single_click_r <= 1'b1;
                        state_r        <= ST_IDLE;
                        cnt_r          <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PRESSED2: begin
                    if (!button_state) begin
                        release_r      <= 1'b1;
                        double_click_r <= 1'b1;
                        held_r         <= 1'b0;
                        state_r        <= ST_IDLE;
                        cnt_r          <= CNT_ZERO;
                    end else if (cnt_r == LONG_LAST) begin
                        long_press_r <= 1'b1;
                        state_r      <= ST_LONG;
                        cnt_r        <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_LOCK;
                    cnt_r   <= CNT_ZERO;
                    held_r  <= 1'b0;
                end
            endcase
        end
    end

    assign press        = press_r;
    assign release_ev   = release_r;
    assign long_press   = long_press_r;
    assign repeat_ev    = repeat_r;
    assign single_click = single_click_r;
    assign double_click = double_click_r;
    assign held         = held_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: expected pulses are queued with their edge number when stimulus is driven.
module tb_button_event_decoder;

    localparam logic [5:0] E_PRESS = 6'b100000;
    localparam logic [5:0] E_REL   = 6'b010000;
    localparam logic [5:0] E_LP    = 6'b001000;
    localparam logic [5:0] E_RPT   = 6'b000100;
    localparam logic [5:0] E_SC    = 6'b000010;
    localparam logic [5:0] E_DC    = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_state = 1'b0;
    logic press, release_ev, long_press, repeat_ev, single_click, double_click, held;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;

    button_event_decoder #(
        .LONG_CYCLES(8), .REPEAT_CYCLES(4), .DCLICK_CYCLES(5), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .button_state(button_state),
        .press(press), .release_ev(release_ev), .long_press(long_press),
        .repeat_ev(repeat_ev), .single_click(single_click),
        .double_click(double_click), .held(held)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    // Drive one edge, then compare the pulse vector with the scoreboard head.
    task automatic step(input logic b);
        logic [5:0] got;
        logic [5:0] want;
        button_state = b;
        @(posedge clk);
        cyc++;
        #1;
        got  = {press, release_ev, long_press, repeat_ev, single_click, double_click};
        want = 6'b000000;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            want = sb[0].vec;
            void'(sb.pop_front());
        end
        check_value($sformatf("events@%0d", cyc), {26'd0, got}, {26'd0, want});
    endtask

    task automatic drive(input logic b, input int cnt);
        for (int i = 0; i < cnt; i++) step(b);
    endtask

    initial begin
        #3;
        check_value("reset_pulses", {26'd0, press, release_ev, long_press, repeat_ev, single_click, double_click}, 32'd0);
        check_value("reset_held", {31'd0, held}, 32'd0);
        drive(1'b0, 2);
        rst = 1'b0;
        drive(1'b0, 2);

        // short press
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 3, E_REL); push_ev(n + 8, E_SC);
        drive(1'b1, 3);
        check_value("held_pressed", {31'd0, held}, 32'd1);
        drive(1'b0, 1);
        check_value("held_released", {31'd0, held}, 32'd0);
        drive(1'b0, 9);

        // double click
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 3, E_REL); push_ev(n + 5, E_PRESS);
        push_ev(n + 8, E_REL | E_DC);
        drive(1'b1, 3); drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 8);

        // long hold with repeats
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 8, E_LP); push_ev(n + 12, E_RPT);
        push_ev(n + 16, E_RPT); push_ev(n + 20, E_REL);
        drive(1'b1, 20);
        check_value("held_long", {31'd0, held}, 32'd1);
        drive(1'b0, 8);

        // long-press boundary: 8 edges high, then 9 edges high
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 8, E_REL); push_ev(n + 13, E_SC);
        drive(1'b1, 8); drive(1'b0, 7);
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 8, E_LP); push_ev(n + 9, E_REL);
        drive(1'b1, 9); drive(1'b0, 7);

        // double-click window boundary: press on the terminal edge wins
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 2, E_REL); push_ev(n + 7, E_PRESS);
        push_ev(n + 9, E_REL | E_DC);
        drive(1'b1, 2); drive(1'b0, 5); drive(1'b1, 2); drive(1'b0, 8);
        // one edge later: single_click first, then a fresh press
        n = cyc + 1;
        push_ev(n, E_PRESS); push_ev(n + 2, E_REL); push_ev(n + 7, E_SC);
        push_ev(n + 8, E_PRESS); push_ev(n + 10, E_REL); push_ev(n + 15, E_SC);
        drive(1'b1, 2); drive(1'b0, 6); drive(1'b1, 2); drive(1'b0, 8);

        // reset while held: nothing until the button goes low then high again
        n = cyc + 1;
        push_ev(n, E_PRESS);
        drive(1'b1, 2);
        rst = 1'b1;
        #1;
        check_value("async_rst_held", {31'd0, held}, 32'd0);
        drive(1'b1, 2);
        rst = 1'b0;
        drive(1'b1, 3);
        check_value("lock_held", {31'd0, held}, 32'd0);
        drive(1'b0, 1);
        push_ev(cyc + 1, E_PRESS);
        drive(1'b1, 1);
        push_ev(cyc + 1, E_REL);
        drive(1'b0, 2);
        // reset inside the double-click window discards the single_click
        rst = 1'b1;
        #1;
        drive(1'b0, 2);
        rst = 1'b0;
        drive(1'b0, 10);

        check_value("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
